// File: rtl/sort_datapath.sv
// sort_datapath
//   Datapath and array storage that answers the bubble-sort control FSM.
//   It holds the register file (N, I, J, K, A, B), an async-read RAM,
//   a shared ALU/comparator and the select muxes steered by the controller.
//   The host loads the array and its length before start and reads the
//   results back after done.
//
// Optional feature (macro SORT_SWAP_COUNT_EN):
//   When defined, adds output swap_count[15:0]. It counts the first half of
//   each swap (write with m3_sel=1), is cleared by clr and saturates at 16'hFFFF.
//   When undefined, the port and the counter do not exist.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   rd, wr                 RAM read qualify / RAM write strobe
//   operation              0 = compare (lt = m1 < m2), 1 = add
//   clr, preset            clear / set the done flag (clr wins)
//   m1_sel..m6_sel         operand, write-data, address and counter-source selects
//   ln, li, lj, lk, la, lb load enables for N, I, J, K, A, B
//   host_we/addr/wdata     host write port into the RAM
//   host_n                 array length, captured on ln and clamped to DEPTH
//   host_rdata             async read of mem[host_addr] (0 when out of range)
//   lt                     comparator result, combinational
//   done                   sort-finished flag
module sort_datapath #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic              operation,
  input  logic              clr,
  input  logic              preset,
  input  logic [1:0]        m1_sel,
  input  logic [1:0]        m2_sel,
  input  logic              m3_sel,
  input  logic [1:0]        m4_sel,
  input  logic              m5_sel,
  input  logic              m6_sel,
  input  logic              ln,
  input  logic              li,
  input  logic              lj,
  input  logic              lk,
  input  logic              la,
  input  logic              lb,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W:0]   host_n,
  output logic [DATA_W-1:0] host_rdata,
  output logic              lt,
  output logic              done
`ifdef SORT_SWAP_COUNT_EN
  ,
  output logic [15:0]       swap_count
`endif
);

  // Counter width: one extra bit so a counter can hold DEPTH itself.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]     n_r, i_r, j_r, k_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic              done_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [CW-1:0]     nlim_s;
  logic [DATA_W-1:0] m1_s, m2_s, wdata_s, rdata_s, host_rdata_s;
  logic [CW-1:0]     alu_s;
  logic              lt_s;
  logic [CW-1:0]     addr_s, host_addr_ext_s, n_next_s;
  logic              addr_ok_s, host_ok_s;

  // Saturating N-1 so an empty array gives a limit of 0 (outer compare fails).
  always_comb begin
    if (n_r == {CW{1'b0}}) begin
      nlim_s = {CW{1'b0}};
    end else begin
      nlim_s = n_r - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // ALU operand A mux.
  always_comb begin
    m1_s = {DATA_W{1'b0}};
    case (m1_sel)
      2'd0:    m1_s = DATA_W'(i_r);
      2'd1:    m1_s = DATA_W'(j_r);
      2'd2:    m1_s = b_r;
      2'd3:    m1_s = {DATA_W{1'b0}};
      default: m1_s = {DATA_W{1'b0}};
    endcase
  end

  // ALU operand B mux.
  always_comb begin
    m2_s = {DATA_W{1'b0}};
    case (m2_sel)
      2'd0:    m2_s = DATA_W'(nlim_s);
      2'd1:    m2_s = a_r;
      2'd2:    m2_s = DATA_W'(1'b1);
      2'd3:    m2_s = {DATA_W{1'b0}};
      default: m2_s = {DATA_W{1'b0}};
    endcase
  end

  // Sums only ever land in counters, so only the counter-width slice is
  // formed; truncating the operands first gives the same low bits.
  assign alu_s = m1_s[CW-1:0] + m2_s[CW-1:0];

  // Unsigned comparator; forced low while the ALU is adding.
  always_comb begin
    if (operation == 1'b0) begin
      lt_s = (m1_s < m2_s);
    end else begin
      lt_s = 1'b0;
    end
  end

  assign lt = lt_s;

  // RAM address mux.
  always_comb begin
    addr_s = {CW{1'b0}};
    case (m4_sel)
      2'd0:    addr_s = i_r;
      2'd1:    addr_s = {1'b0, host_addr};
      2'd2:    addr_s = k_r;
      2'd3:    addr_s = j_r;
      default: addr_s = {CW{1'b0}};
    endcase
  end

  assign addr_ok_s       = (addr_s < DEPTH_C);
  assign host_addr_ext_s = {1'b0, host_addr};
  assign host_ok_s       = (host_addr_ext_s < DEPTH_C);
  assign wdata_s         = m3_sel ? b_r : a_r;

  // Controller read port: out-of-range addresses read as zero.
  always_comb begin
    if (addr_ok_s) begin
      rdata_s = mem_r[addr_s[ADDR_W-1:0]];
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end
  end

  // Host read port: out-of-range addresses read as zero.
  always_comb begin
    if (host_ok_s) begin
      host_rdata_s = mem_r[host_addr];
    end else begin
      host_rdata_s = {DATA_W{1'b0}};
    end
  end

  assign host_rdata = host_rdata_s;

  // Array length clamped to the storage size.
  always_comb begin
    if (host_n > DEPTH_C) begin
      n_next_s = DEPTH_C;
    end else begin
      n_next_s = host_n;
    end
  end

  // Register file and done flag; A/B load only when the read is qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r    <= {CW{1'b0}};
      i_r    <= {CW{1'b0}};
      j_r    <= {CW{1'b0}};
      k_r    <= {CW{1'b0}};
      a_r    <= {DATA_W{1'b0}};
      b_r    <= {DATA_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      if (ln) n_r <= n_next_s;
      if (li) i_r <= m5_sel ? alu_s : {CW{1'b0}};
      if (lj) j_r <= m6_sel ? alu_s : {CW{1'b0}};
      if (lk) k_r <= alu_s;
      if (la && rd) a_r <= rdata_s;
      if (lb && rd) b_r <= rdata_s;
      if (clr) begin
        done_r <= 1'b0;
      end else if (preset) begin
        done_r <= 1'b1;
      end
    end
  end

  assign done = done_r;

  // Array storage, deliberately not reset; controller write beats host write.
  always_ff @(posedge clk) begin
    if (wr) begin
      if (addr_ok_s) begin
        mem_r[addr_s[ADDR_W-1:0]] <= wdata_s;
      end
    end else if (host_we && host_ok_s) begin
      mem_r[host_addr] <= host_wdata;
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  logic [15:0] swap_cnt_r;

  // Counts first halves of swaps, cleared with done, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_r <= 16'h0000;
    end else if (clr) begin
      swap_cnt_r <= 16'h0000;
    end else if (wr && m3_sel && (swap_cnt_r != 16'hFFFF)) begin
      swap_cnt_r <= swap_cnt_r + 16'h0001;
    end
  end

  assign swap_count = swap_cnt_r;
`endif

endmodule

// File: tb/tb_sort_datapath.sv
// Directed bench for sort_datapath; the bench plays the controller and keeps
// expected values in a scoreboard queue.
module tb_sort_datapath;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rd, wr, operation, clr, preset;
  logic [1:0]        m1_sel, m2_sel, m4_sel;
  logic              m3_sel, m5_sel, m6_sel;
  logic              ln, li, lj, lk, la, lb;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [ADDR_W:0]   host_n;
  logic [DATA_W-1:0] host_rdata;
  logic              lt, done;
`ifdef SORT_SWAP_COUNT_EN
  logic [15:0]       swap_count;
`endif

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int arr[8];
  int swaps_model = 0;

  always #5 clk = ~clk;

  sort_datapath #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .wr(wr), .operation(operation),
    .clr(clr), .preset(preset), .m1_sel(m1_sel), .m2_sel(m2_sel),
    .m3_sel(m3_sel), .m4_sel(m4_sel), .m5_sel(m5_sel), .m6_sel(m6_sel),
    .ln(ln), .li(li), .lj(lj), .lk(lk), .la(la), .lb(lb),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_n(host_n), .host_rdata(host_rdata), .lt(lt), .done(done)
`ifdef SORT_SWAP_COUNT_EN
    , .swap_count(swap_count)
`endif
  );

  task automatic idle();
    rd = 1'b0; wr = 1'b0; operation = 1'b0; clr = 1'b0; preset = 1'b0;
    m1_sel = 2'd0; m2_sel = 2'd0; m3_sel = 1'b0; m4_sel = 2'd0;
    m5_sel = 1'b0; m6_sel = 1'b0;
    ln = 1'b0; li = 1'b0; lj = 1'b0; lk = 1'b0; la = 1'b0; lb = 1'b0;
    host_we = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      e = 16'hDEAD;
    end else begin
      e = exp_q.pop_front();
    end
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic lt_probe(input string tag, input logic [1:0] s1,
                          input logic [1:0] s2, input logic op, input logic e);
    m1_sel = s1; m2_sel = s2; operation = op;
    push({15'd0, e});
    #1;
    check(tag, {15'd0, lt});
    idle();
  endtask

  task automatic host_wr(input int a, input int d);
    host_we = 1'b1; host_addr = ADDR_W'(a); host_wdata = DATA_W'(d);
    tick();
  endtask

  task automatic host_rd(input string tag, input int a, input int e);
    host_addr = ADDR_W'(a);
    push(16'(e));
    #1;
    check(tag, {8'h00, host_rdata});
  endtask

  task automatic done_chk(input string tag, input logic e);
    push({15'd0, e});
    check(tag, {15'd0, done});
  endtask

  task automatic load_n(input int v);
    host_n = (ADDR_W + 1)'(v); ln = 1'b1;
    tick();
  endtask

  // J <= 0 + NLIM
  task automatic j_to_nlim();
    lj = 1'b1; m6_sel = 1'b1; m1_sel = 2'd3; m2_sel = 2'd0; operation = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    host_addr = '0; host_wdata = '0; host_n = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Preload and run some activity before a mid-run reset
    host_wr(0, 5); host_wr(1, 3); host_wr(5, 8'h11); host_wr(15, 8'h77);
    load_n(4);
    preset = 1'b1; tick();
    j_to_nlim();
    la = 1'b1; rd = 1'b1; m4_sel = 2'd1; host_addr = '0; tick();
    done_chk("pre_rst_done", 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    done_chk("rst_done_async", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lt_probe("rst_lt_default", 2'd0, 2'd0, 1'b0, 1'b0);
    lt_probe("rst_n_zero", 2'd3, 2'd0, 1'b0, 1'b0);
    lt_probe("rst_j_zero", 2'd1, 2'd2, 1'b0, 1'b1);
    lt_probe("rst_i_zero", 2'd0, 2'd2, 1'b0, 1'b1);
    lt_probe("rst_a_zero", 2'd3, 2'd1, 1'b0, 1'b0);
    lt_probe("rst_b_zero", 2'd2, 2'd2, 1'b0, 1'b1);
    host_rd("rst_ram0", 0, 5);
    host_rd("rst_ram1", 1, 3);

    // N=4: J=0 < NLIM, then J=NLIM=3
    load_n(4);
    lt_probe("j0_lt_nlim", 2'd1, 2'd0, 1'b0, 1'b1);
    j_to_nlim();
    lt_probe("j3_lt_nlim", 2'd1, 2'd0, 1'b0, 1'b0);
    lt_probe("add_forces_lt0", 2'd3, 2'd2, 1'b1, 1'b0);

    // Load A/B through the address mux, K from the ALU
    host_wr(2, 9); host_wr(3, 4);
    li = 1'b1; m5_sel = 1'b1; m1_sel = 2'd3; m2_sel = 2'd2; operation = 1'b1; tick();
    li = 1'b1; m5_sel = 1'b1; m1_sel = 2'd0; m2_sel = 2'd2; operation = 1'b1; tick();
    la = 1'b1; rd = 1'b1; m4_sel = 2'd0; m1_sel = 2'd0; m2_sel = 2'd2;
    operation = 1'b1; lk = 1'b1; tick();
    lb = 1'b1; rd = 1'b1; m4_sel = 2'd2; tick();
    lt_probe("b4_lt_a9", 2'd2, 2'd1, 1'b0, 1'b1);
    la = 1'b1; rd = 1'b0; m4_sel = 2'd1; host_addr = 4'd1; tick();
    lt_probe("a_hold_no_rd", 2'd2, 2'd1, 1'b0, 1'b1);

    // Swap, with a colliding host write that must be lost
    wr = 1'b1; m4_sel = 2'd0; m3_sel = 1'b1;
    host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'hAA; tick();
    wr = 1'b1; m4_sel = 2'd2; m3_sel = 1'b0; tick();
    host_rd("swap_mem2", 2, 4);
    host_rd("swap_mem3", 3, 9);
    host_rd("host_write_lost", 5, 8'h11);
`ifdef SORT_SWAP_COUNT_EN
    push(16'd1);
    check("swap_cnt_one", swap_count);
`endif

    // done flag: set, clr priority, hold, clear
    preset = 1'b1; tick();
    done_chk("done_set", 1'b1);
    preset = 1'b1; clr = 1'b1; tick();
    done_chk("done_clr_wins", 1'b0);
    preset = 1'b1; tick();
    tick();
    done_chk("done_hold", 1'b1);
    clr = 1'b1; tick();
    done_chk("done_clr", 1'b0);

    // N=0 saturates NLIM at 0 (I=2 < NLIM must be false)
    load_n(0);
    lt_probe("n0_nlim_zero", 2'd0, 2'd0, 1'b0, 1'b0);
    // N=31 clamps to 16 -> NLIM=15, J=15 reads mem[15]
    load_n(31);
    lj = 1'b1; m6_sel = 1'b0; tick();
    j_to_nlim();
    lt_probe("n16_j_eq_nlim", 2'd1, 2'd0, 1'b0, 1'b0);
    la = 1'b1; rd = 1'b1; m4_sel = 2'd3; tick();
    lt_probe("n16_read15", 2'd3, 2'd1, 1'b0, 1'b1);
    // J = I + NLIM = 17: out-of-range read gives 0, write dropped
    lj = 1'b1; m6_sel = 1'b1; m1_sel = 2'd0; m2_sel = 2'd0; operation = 1'b1; tick();
    la = 1'b1; rd = 1'b1; m4_sel = 2'd3; tick();
    lt_probe("oob_read_zero", 2'd3, 2'd1, 1'b0, 1'b0);
    wr = 1'b1; m4_sel = 2'd3; m3_sel = 1'b0; tick();
    host_rd("oob_write_drop", 1, 3);

    // Bench-driven bubble sort of 7..0
    clr = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      arr[k] = 7 - k;
      host_wr(k, arr[k]);
    end
    load_n(8);
    for (int p = 0; p < 7; p++) begin
      lj = 1'b1; m6_sel = 1'b0; tick();
      for (int q = 0; q < 7 - p; q++) begin
        la = 1'b1; rd = 1'b1; m4_sel = 2'd3; m1_sel = 2'd1; m2_sel = 2'd2;
        operation = 1'b1; lk = 1'b1; tick();
        lb = 1'b1; rd = 1'b1; m4_sel = 2'd2; tick();
        lt_probe("sort_cmp", 2'd2, 2'd1, 1'b0, (arr[q+1] < arr[q]) ? 1'b1 : 1'b0);
        if (arr[q+1] < arr[q]) begin
          int t;
          t = arr[q]; arr[q] = arr[q+1]; arr[q+1] = t;
          swaps_model++;
          wr = 1'b1; m4_sel = 2'd3; m3_sel = 1'b1; tick();
          wr = 1'b1; m4_sel = 2'd2; m3_sel = 1'b0; tick();
        end
        lj = 1'b1; m6_sel = 1'b1; m1_sel = 2'd1; m2_sel = 2'd2; operation = 1'b1; tick();
      end
    end
    preset = 1'b1; tick();
    done_chk("sort_done", 1'b1);
`ifdef SORT_SWAP_COUNT_EN
    push(16'(swaps_model));
    check("swap_cnt_28", swap_count);
`endif
    for (int k = 0; k < 8; k++) begin
      host_rd("sorted_ram", k, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
